mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the single word-wide main-memory port between the instruction cache (I-side, line reads) and the data cache (D-side, line reads or line write-backs) in the cached pipelined TSC CPU. Each granted transaction is a burst of LINE_WORDS word accesses. The arbiter sequences the burst addresses and returns read words to the owner. The D-side has priority because it belongs to the older instruction. A streak limit prevents I-side starvation.

## Interface
- WORD_SIZE, 16, data/address width
- LINE_WORDS, 4, words per burst (power of two, ≥2); IDX = log2(LINE_WORDS)
- MAX_D_STREAK, 2, consecutive D grants allowed while I waits
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  I-side line-fill request; held until i_done
- i_addr  in  WORD_SIZE  I-side address; low IDX bits ignored
- d_req  in  1  D-side request; held until d_done
- d_we  in  1  D-side: 1 = write-back burst, 0 = line fill
- d_addr  in  WORD_SIZE  D-side address; low IDX bits ignored
- d_wdata  in  WORD_SIZE  write word selected by word_idx (combinational from D cache)
- mem_req  out  1  memory access valid
- mem_we  out  1  memory write
- mem_addr  out  WORD_SIZE  {base[WORD_SIZE-1:IDX], word_idx}
- mem_wdata  out  WORD_SIZE  = d_wdata during a D write burst, else 0
- mem_ack  in  1  memory accepted/completed current word this cycle
- mem_rdata  in  WORD_SIZE  read word, valid with mem_ack
- word_idx  out  IDX  index of the word currently on the memory port
- rdata  out  WORD_SIZE  registered read word
- rword  out  IDX  index of rdata
- i_rvalid, d_rvalid  out  1 each  rdata belongs to I / D
- i_done, d_done  out  1 each  one-cycle burst-complete pulse

## Operation
- States: IDLE, BURST_I, BURST_D, FINISH.
- IDLE arbitration, sampled at the clock edge:
  - d_req only → BURST_D.
  - i_req only → BURST_I.
  - Both → BURST_D, unless d_streak == MAX_D_STREAK, in which case BURST_I.
- d_streak (saturating):
  - +1 on each D grant made while i_req = 1.
  - Cleared on any I grant.
  - Cleared on a D grant made while i_req = 0.
- On grant:
  - Latch base address (i_addr or d_addr) and d_we (0 for I).
  - Clear word_idx to 0.
  - Record the owner.
- BURST_x:
  - mem_req = 1; mem_we = latched we.
  - Each cycle with mem_ack = 1 advances word_idx.
  - A read ack registers mem_rdata → rdata, word_idx → rword, and pulses the owner's rvalid next cycle.
  - Ack at word_idx == LINE_WORDS-1 → FINISH.
- FINISH:
  - mem_req = 0; owner's done = 1 for one cycle; → IDLE.
  - Requester drops req in the next cycle. IDLE never re-grants in the FINISH cycle.
- Requests are not cancellable once granted. A req deassert mid-burst is ignored.
- mem_ack is ignored outside BURST states.
- word_idx wraps only by leaving BURST. The address never crosses the line boundary.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE; d_streak 0; word_idx 0; latched base/we 0.
  - mem_req, mem_we, rvalids and dones 0; mem_addr, mem_wdata, rdata and rword 0.
- Reset mid-burst aborts the burst with no done pulse. The memory sees mem_req fall asynchronously.
- Grant latency: req seen high at edge N → mem_req high from cycle N+1.
- Zero-wait memory (ack every cycle), LINE_WORDS = 4:
  - mem_req in cycles N+1..N+4.
  - rvalid in N+2..N+5.
  - done in N+5, coincident with the last rvalid.
- Wait states: each cycle without an ack holds mem_addr and mem_wdata stable and delays all later events by one cycle.
- Write bursts: no rvalid. done arrives one cycle after the last ack.
- mem_addr, mem_we and word_idx are stable for the whole time mem_req is high for a given word.

## Test plan
- I-only fill, i_addr=0x1236, ack every cycle:
  - mem_addr 0x1234, 0x1235, 0x1236, 0x1237.
  - i_rvalid ×4 with rword 0..3.
  - i_done 5 cycles after the grant edge; d_* outputs stay 0.
- D write-back, d_addr=0x0040, d_wdata=0xA000+word_idx, ack gaps of 2 cycles:
  - mem_we=1; mem_wdata 0xA000..0xA003 held across the gaps.
  - No rvalid; single d_done.
- i_req and d_req raised together:
  - D granted first; I granted immediately after.
  - d_streak returns to 0 after the I grant.
- Starvation, MAX_D_STREAK=2, i_req held with d_req re-raised after every d_done:
  - Grant order D, D, I, D, D, I.
- Reset asserted mid-burst after the 2nd ack:
  - Outputs go to reset values immediately, no done.
  - After release with i_req high, a fresh burst starts at word 0.
- Stray mem_ack in IDLE and FINISH:
  - No state change and no rvalid.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between I-cache line fills and D-cache fills/write-backs
module mem_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int LINE_WORDS   = 4,
  parameter int MAX_D_STREAK = 2,
  localparam int IDX         = $clog2(LINE_WORDS),
  localparam int SW          = $clog2(MAX_D_STREAK + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [IDX-1:0]       word_idx,
  output logic [WORD_SIZE-1:0] rdata,
  output logic [IDX-1:0]       rword,
  output logic                 i_rvalid,
  output logic                 d_rvalid,
  output logic                 i_done,
  output logic                 d_done
);
  typedef enum logic [1:0] {IDLE, BURST_I, BURST_D, FINISH} state_t;
  state_t state, state_nx;
  logic [WORD_SIZE-1:IDX] base;
  logic we, owner_d, grant_i, grant_d, burst, last;
  logic [IDX-1:0] idx;
  logic [SW-1:0] streak;
  logic unused_low_addr;
  assign unused_low_addr = ^{i_addr[IDX-1:0], d_addr[IDX-1:0]};
  assign burst = (state == BURST_I) || (state == BURST_D);
  assign last = idx == IDX'(LINE_WORDS - 1);
  always_comb begin
    state_nx = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        // D wins ties unless I has already waited through MAX_D_STREAK D bursts
        grant_d = d_req && (!i_req || streak != SW'(MAX_D_STREAK));
        grant_i = i_req && !grant_d;
        state_nx = grant_d ? BURST_D : grant_i ? BURST_I : IDLE;
      end
      BURST_I, BURST_D: state_nx = (mem_ack && last) ? FINISH : state;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      base <= '0;
      we <= 1'b0;
      owner_d <= 1'b0;
      idx <= '0;
      streak <= '0;
      rdata <= '0;
      rword <= '0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
    end else begin
      state <= state_nx;
      i_rvalid <= burst && mem_ack && !we && !owner_d;
      d_rvalid <= burst && mem_ack && !we && owner_d;
      if (grant_i || grant_d) begin
        base <= grant_d ? d_addr[WORD_SIZE-1:IDX] : i_addr[WORD_SIZE-1:IDX];
        we <= grant_d && d_we;
        owner_d <= grant_d;
        idx <= '0;
      end else if (burst && mem_ack) begin
        idx <= idx + 1'b1;
      end
      if (burst && mem_ack && !we) begin
        rdata <= mem_rdata;
        rword <= idx;
      end
      // a D grant with I waiting implies streak < MAX, so the increment cannot overflow
      if (grant_d) streak <= i_req ? streak + 1'b1 : '0;
      else if (grant_i) streak <= '0;
    end
  end
  assign mem_req = burst;
  assign mem_we = burst && we;
  assign mem_addr = {base, idx};
  assign mem_wdata = (burst && we) ? d_wdata : '0;
  assign word_idx = idx;
  assign i_done = (state == FINISH) && !owner_d;
  assign d_done = (state == FINISH) && owner_d;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cache/memory agents with a transaction-level reference model of the arbiter
module tb_mem_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wbase = '0;
  logic [15:0] d_wdata, mem_rdata, mem_addr, mem_wdata, rdata;
  logic mem_req, mem_we, i_rvalid, d_rvalid, i_done, d_done;
  logic [1:0] word_idx, rword;
  always #5 clk = ~clk;
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A5A;
  endfunction
  assign mem_rdata = memf(mem_addr);
  assign d_wdata = d_wbase ^ {14'd0, word_idx};
  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_addr(i_addr), .d_req(d_req),
    .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .word_idx(word_idx), .rdata(rdata), .rword(rword), .i_rvalid(i_rvalid),
    .d_rvalid(d_rvalid), .i_done(i_done), .d_done(d_done)
  );
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  // reference model: one outstanding burst, its owner, progress and the pending result events
  bit m_busy, m_owner_d, m_we, fin;
  logic [1:0] m_idx;
  logic [15:0] m_base, m_wbase, exp_rdata;
  logic [1:0] exp_rword;
  int m_streak, exp_rv, exp_done;
  int i_left, d_left, req_pct = 100, ack_pct = 100, ack_gap = 0, gap_cnt, we_mode;
  bit i_fix_en, d_fix_en, seen_first;
  logic [15:0] i_fix, d_fix, w_fix, first_addr, order_bits;
  int cyc, req_cyc, done_cyc, n_irv, n_drv, n_idone, n_ddone;
  task automatic sample();
    @(negedge clk);
    cyc++;
    check("mem_req", mem_req, m_busy);
    if (m_busy) begin
      check("mem_addr", mem_addr, {m_base[15:2], m_idx});
      check("word_idx", word_idx, m_idx);
      check("mem_we", mem_we, m_we);
      check("mem_wdata", mem_wdata, m_we ? (m_wbase ^ {14'd0, m_idx}) : 16'h0);
    end else begin
      check("idle_we", mem_we, 0);
      check("idle_wdata", mem_wdata, 0);
    end
    check("i_rvalid", i_rvalid, exp_rv == 1);
    check("d_rvalid", d_rvalid, exp_rv == 2);
    if (exp_rv != 0) begin
      check("rdata", rdata, exp_rdata);
      check("rword", rword, exp_rword);
    end
    check("i_done", i_done, exp_done == 1);
    check("d_done", d_done, exp_done == 2);
    if (mem_req && !seen_first) begin
      seen_first = 1;
      first_addr = mem_addr;
      req_cyc = cyc;
    end
    n_irv += int'(i_rvalid);
    n_drv += int'(d_rvalid);
    if (i_done || d_done) begin
      order_bits = {order_bits[14:0], d_done};
      done_cyc = cyc;
    end
    n_idone += int'(i_done);
    n_ddone += int'(d_done);
    if (i_done) i_req = 1'b0;
    if (d_done) d_req = 1'b0;
    fin = exp_done != 0;
  endtask
  task automatic drive_predict();
    if (!i_req && !i_done && i_left > 0 && $urandom_range(99) < req_pct) begin
      i_req = 1'b1;
      i_addr = i_fix_en ? i_fix : 16'($urandom);
      i_left--;
    end
    if (!d_req && !d_done && d_left > 0 && $urandom_range(99) < req_pct) begin
      d_req = 1'b1;
      d_addr = d_fix_en ? d_fix : 16'($urandom);
      d_we = (we_mode == 2) ? 1'($urandom) : 1'(we_mode);
      d_wbase = d_fix_en ? w_fix : 16'($urandom);
      d_left--;
    end
    mem_ack = (ack_gap > 0) ? (gap_cnt % (ack_gap + 1) == 0) : ($urandom_range(99) < ack_pct);
    gap_cnt++;
    exp_rv = 0;
    exp_done = 0;
    if (m_busy) begin
      if (mem_ack) begin
        if (!m_we) begin
          exp_rv = m_owner_d ? 2 : 1;
          exp_rdata = memf({m_base[15:2], m_idx});
          exp_rword = m_idx;
        end
        if (m_idx == 2'd3) begin
          m_busy = 0;
          exp_done = m_owner_d ? 2 : 1;
        end else m_idx++;
      end
    end else if (!fin && (d_req || i_req)) begin
      m_owner_d = d_req && (!i_req || m_streak < 2);
      m_streak = m_owner_d && i_req ? m_streak + 1 : 0;
      m_busy = 1;
      m_idx = 0;
      m_base = m_owner_d ? d_addr : i_addr;
      m_we = m_owner_d && d_we;
      m_wbase = d_wbase;
    end
  endtask
  function automatic bit quiet();
    return i_left == 0 && d_left == 0 && !i_req && !d_req && !m_busy && exp_done == 0 && exp_rv == 0;
  endfunction
  task automatic run(input string tag, input int budget);
    int n = 0;
    do begin
      sample();
      drive_predict();
      n++;
    end while (!quiet() && n < budget);
    check({tag, "_quiesce"}, quiet(), 1);
  endtask
  task automatic start_phase(input int il, input int dl);
    i_left = il;
    d_left = dl;
    seen_first = 0;
    order_bits = '0;
    n_irv = 0; n_drv = 0; n_idone = 0; n_ddone = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", rdata, 0);
    sample();
    reset_n = 1'b1;
    // I-only fill at 0x1236, zero wait states
    start_phase(1, 0);
    i_fix_en = 1; i_fix = 16'h1236;
    drive_predict();
    run("ionly", 50);
    check("ionly_first_addr", first_addr, 16'h1234);
    check("ionly_rvalids", n_irv, 4);
    check("ionly_done", n_idone, 1);
    check("ionly_d_activity", n_drv + n_ddone, 0);
    check("ionly_done_lat", done_cyc - req_cyc, 4);
    // D write-back with two idle cycles between acks
    start_phase(0, 1);
    d_fix_en = 1; d_fix = 16'h0040; w_fix = 16'hA000; we_mode = 1; ack_gap = 2;
    run("dwb", 100);
    check("dwb_first_addr", first_addr, 16'h0040);
    check("dwb_rvalids", n_irv + n_drv, 0);
    check("dwb_done", n_ddone, 1);
    // simultaneous requests: D first, then I
    start_phase(1, 1);
    d_fix_en = 0; i_fix_en = 0; we_mode = 2; ack_gap = 0; ack_pct = 100;
    run("both", 100);
    check("both_order", order_bits, 16'b10);
    check("both_count", n_idone + n_ddone, 2);
    // starvation guard: I held, D re-raised after every d_done
    start_phase(2, 4);
    run("starve", 200);
    check("starve_order", order_bits, 16'b110110);
    // reset in the middle of a burst
    start_phase(1, 0);
    i_fix_en = 1; i_fix = 16'h0522; we_mode = 0;
    begin
      int n = 0;
      do begin
        sample();
        drive_predict();
        n++;
      end while (!(m_busy && m_idx == 2'd2) && n < 20);
    end
    check("rst_reach", m_busy && m_idx == 2'd2, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_word_idx", word_idx, 0);
    check("arst_rdata", rdata, 0);
    check("arst_rword", rword, 0);
    check("arst_i_rvalid", i_rvalid, 0);
    check("arst_i_done", i_done, 0);
    m_busy = 0; exp_rv = 0; exp_done = 0; m_streak = 0;
    n_idone = 0;
    seen_first = 0;
    sample();
    reset_n = 1'b1;
    drive_predict();
    run("rst", 40);
    check("rst_fresh_addr", first_addr, 16'h0520);
    check("rst_done_count", n_idone, 1);
    // randomized traffic with random wait states and stray acks
    start_phase(40, 40);
    i_fix_en = 0; we_mode = 2; req_pct = 30; ack_pct = 60;
    run("rand", 8000);
    check("rand_dones", n_idone + n_ddone, 80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
